// File: rtl/alarm_clock_multi.sv
// Alarm clock: BCD 24h time with a minute prescaler, NUM_ALARMS armed alarms, digit-wise load editing.
// Latency: edits, ticks and ring flags update on the clock edge after the request; reset is asynchronous.
// No backpressure: every input is sampled each cycle. Build with SNOOZE_EN defined to add per-alarm snooze.
module alarm_clock_multi #(
  parameter int NUM_ALARMS    = 2,
  parameter int TICKS_PER_MIN = 60,
  parameter int RING_MIN      = 1,
  parameter int SNOOZE_MIN    = 5,
  localparam int SELW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  min_rst,
  input  logic                  en,
  input  logic                  clock_load,
  input  logic                  alarm_load,
  input  logic [SELW-1:0]       alarm_sel,
  input  logic                  load_num_rst,
  input  logic [1:0]            load_up_down,
  input  logic [1:0]            load_left_right,
  input  logic [NUM_ALARMS-1:0] alarm_arm,
  input  logic                  snooze,
  input  logic                  ack,
  output logic [1:0]            cursor,
  output logic [15:0]           clock_out,
  output logic [15:0]           alarm_out,
  output logic [NUM_ALARMS-1:0] ring_id
);

  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int RW = (RING_MIN > 1) ? $clog2(RING_MIN) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_MIN - 1);

  typedef enum logic [1:0] {MODE_RUN, MODE_CLOCK, MODE_ALARM} mode_t;

  mode_t                            mode, mode_q;
  logic [PW-1:0]                    presc_q;
  logic [15:0]                      time_q, time_next;
  logic [NUM_ALARMS-1:0][15:0]      alarm_q;
  logic [1:0]                       cursor_q, cur_eff;
  logic [NUM_ALARMS-1:0]            ring_q, match, rering;
  logic [NUM_ALARMS-1:0][RW-1:0]    ring_cnt;
  logic                             entry, act_up, act_dn, act_l, act_r;
  logic                             sel_ok, digit_write, tick;
  logic [15:0]                      sel_alarm, clock_edit, alarm_edit;

  // Largest legal value of the digit at pos; HR_0 tops out at 3 in the 20s.
  function automatic logic [3:0] digit_max(input logic [1:0] pos, input logic [15:0] v);
    case (pos)
      2'd0:    digit_max = 4'd9;
      2'd1:    digit_max = 4'd5;
      2'd2:    digit_max = (v[15:12] == 4'd2) ? 4'd3 : 4'd9;
      default: digit_max = 4'd2;
    endcase
  endfunction

  // Apply one edit action to the digit under the cursor, then keep HR_0 legal.
  function automatic logic [15:0] edit_bcd(input logic [15:0] v, input logic [1:0] pos,
                                           input logic clr, input logic up, input logic dn);
    logic [15:0] r;
    logic [3:0]  d, mx;
    r  = v;
    d  = v[{pos, 2'b00} +: 4];
    mx = digit_max(pos, v);
    if (clr)     d = 4'd0;
    else if (up) d = (d >= mx) ? 4'd0 : d + 4'd1;
    else if (dn) d = (d == 4'd0) ? mx : d - 4'd1;
    r[{pos, 2'b00} +: 4] = d;
    if (r[15:12] == 4'd2 && r[11:8] > 4'd3) r[11:8] = 4'd3;
    return r;
  endfunction

  // One minute later, with BCD carries and 23:59 -> 00:00.
  function automatic logic [15:0] next_time(input logic [15:0] t);
    logic [3:0] h1, h0, m1, m0;
    {h1, h0, m1, m0} = t;
    if (m0 != 4'd9) m0 = m0 + 4'd1;
    else begin
      m0 = 4'd0;
      if (m1 != 4'd5) m1 = m1 + 4'd1;
      else begin
        m1 = 4'd0;
        if (h1 == 4'd2 && h0 == 4'd3) begin h1 = 4'd0; h0 = 4'd0; end
        else if (h0 == 4'd9)          begin h0 = 4'd0; h1 = h1 + 4'd1; end
        else                          h0 = h0 + 4'd1;
      end
    end
    return {h1, h0, m1, m0};
  endfunction

  // Load mode decode, one-hot action priority and the minute tick.
  always_comb begin
    mode        = clock_load ? MODE_CLOCK : (alarm_load ? MODE_ALARM : MODE_RUN);
    entry       = (mode != MODE_RUN) && (mode != mode_q);
    cur_eff     = entry ? 2'd0 : cursor_q;
    act_up      = !load_num_rst && (load_up_down == 2'b10);
    act_dn      = !load_num_rst && (load_up_down == 2'b01);
    act_l       = !load_num_rst && !act_up && !act_dn && (load_left_right == 2'b10);
    act_r       = !load_num_rst && !act_up && !act_dn && (load_left_right == 2'b01);
    sel_ok      = int'(alarm_sel) < NUM_ALARMS;
    sel_alarm   = sel_ok ? alarm_q[alarm_sel] : 16'h0000;
    clock_edit  = edit_bcd(time_q, cur_eff, load_num_rst, act_up, act_dn);
    alarm_edit  = edit_bcd(sel_alarm, cur_eff, load_num_rst, act_up, act_dn);
    digit_write = (mode == MODE_CLOCK) && (load_num_rst || act_up || act_dn);
    tick        = en && !clock_load && !min_rst && (presc_q == PRESC_LAST);
    time_next   = next_time(time_q);
    for (int k = 0; k < NUM_ALARMS; k++)
      match[k] = tick && alarm_arm[k] && (time_next == alarm_q[k]);
  end

  // Mode register, prescaler, time, alarm registers and cursor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_RUN;
      presc_q  <= '0;
      time_q   <= 16'h0000;
      alarm_q  <= '0;
      cursor_q <= 2'd0;
    end else begin
      mode_q <= mode;
      if (min_rst || digit_write)      presc_q <= '0;
      else if (en && !clock_load)      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      if (mode == MODE_CLOCK)          time_q <= clock_edit;
      else if (tick)                   time_q <= time_next;
      if (mode == MODE_ALARM && sel_ok) alarm_q[alarm_sel] <= alarm_edit;
      if (mode != MODE_RUN)
        cursor_q <= act_l ? cur_eff + 2'd1 : (act_r ? cur_eff - 2'd1 : cur_eff);
    end
  end

`ifdef SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MIN + 1);
  logic [NUM_ALARMS-1:0]         snz_vld;
  logic [NUM_ALARMS-1:0][SW-1:0] snz_cnt;
  logic                          unused_snooze;
  assign unused_snooze = 1'b0;

  // A snoozed alarm re-rings on the tick where its countdown expires.
  always_comb begin
    for (int k = 0; k < NUM_ALARMS; k++)
      rering[k] = snz_vld[k] && (snz_cnt[k] == SW'(1));
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign rering        = '0;
`endif

  // Per-alarm ring flag: ack/disarm first, then snooze, then tick-driven set or auto-stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_q   <= '0;
      ring_cnt <= '0;
`ifdef SNOOZE_EN
      snz_vld  <= '0;
      snz_cnt  <= '0;
`endif
    end else begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (ack || !alarm_arm[k]) begin
          ring_q[k]   <= 1'b0;
          ring_cnt[k] <= '0;
`ifdef SNOOZE_EN
          snz_vld[k]  <= 1'b0;
`endif
        end
`ifdef SNOOZE_EN
        else if (snooze && ring_q[k]) begin
          ring_q[k]   <= 1'b0;
          ring_cnt[k] <= '0;
          snz_vld[k]  <= 1'b1;
          snz_cnt[k]  <= SW'(SNOOZE_MIN);
        end
`endif
        else if (tick) begin
          if (match[k] || rering[k]) begin
            ring_q[k]   <= 1'b1;
            ring_cnt[k] <= '0;
          end else if (ring_q[k]) begin
            if (ring_cnt[k] == RING_LAST) begin
              ring_q[k]   <= 1'b0;
              ring_cnt[k] <= '0;
            end else begin
              ring_cnt[k] <= ring_cnt[k] + RW'(1);
            end
          end
`ifdef SNOOZE_EN
          if (rering[k])       snz_vld[k] <= 1'b0;
          else if (snz_vld[k]) snz_cnt[k] <= snz_cnt[k] - SW'(1);
`endif
        end
      end
    end
  end

  assign cursor    = cursor_q;
  assign clock_out = time_q;
  assign alarm_out = sel_alarm;
  assign ring_id   = ring_q;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi with TICKS_PER_MIN=4, NUM_ALARMS=2, RING_MIN=1, SNOOZE_MIN=5.
// Inputs are driven 1 time unit after each rising edge; outputs are checked at the same point.
// The snooze scenario follows whichever build (SNOOZE_EN defined or not) is being compiled.
module tb_alarm_clock_multi;

  logic        clk = 1'b0;
  logic        rst, min_rst, en, clock_load, alarm_load, load_num_rst, snooze, ack;
  logic [0:0]  alarm_sel;
  logic [1:0]  load_up_down, load_left_right, alarm_arm, cursor, ring_id;
  logic [15:0] clock_out, alarm_out;
  int          tests = 0;
  int          fails = 0;

  alarm_clock_multi #(.NUM_ALARMS(2), .TICKS_PER_MIN(4), .RING_MIN(1), .SNOOZE_MIN(5)) dut (
    .clk(clk), .rst(rst), .min_rst(min_rst), .en(en), .clock_load(clock_load),
    .alarm_load(alarm_load), .alarm_sel(alarm_sel), .load_num_rst(load_num_rst),
    .load_up_down(load_up_down), .load_left_right(load_left_right), .alarm_arm(alarm_arm),
    .snooze(snooze), .ack(ack), .cursor(cursor), .clock_out(clock_out),
    .alarm_out(alarm_out), .ring_id(ring_id)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic [1:0] u, input logic [1:0] l, input logic c, input int n);
    load_up_down = u; load_left_right = l; load_num_rst = c;
    cyc(n);
    load_up_down = 2'b00; load_left_right = 2'b00; load_num_rst = 1'b0;
  endtask

  // Writes v digit by digit, HR_1 first; expects cursor 0 on entry and leaves it at 0.
  task automatic load_value(input logic [15:0] v);
    press(2'b00, 2'b01, 1'b0, 1);
    for (int i = 3; i >= 0; i--) begin
      press(2'b00, 2'b00, 1'b1, 1);
      press(2'b10, 2'b00, 1'b0, int'(v[i*4 +: 4]));
      if (i > 0) press(2'b00, 2'b01, 1'b0, 1);
    end
  endtask

  task automatic set_time(input logic [15:0] v);
    clock_load = 1'b1; cyc(1);
    load_value(v);
    clock_load = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tests++; if (clock_out !== 16'h0000) begin fails++; $display("FAIL reset_clock: got %h expected 0000", clock_out); end
    tests++; if (alarm_out !== 16'h0000) begin fails++; $display("FAIL reset_alarm: got %h expected 0000", alarm_out); end
    tests++; if (cursor !== 2'd0) begin fails++; $display("FAIL reset_cursor: got %0d expected 0", cursor); end
    tests++; if (ring_id !== 2'b00) begin fails++; $display("FAIL reset_ring: got %b expected 00", ring_id); end
    cyc(2); rst = 1'b1; cyc(1);
  endtask

  task automatic test_load_2359;
    clock_load = 1'b1; cyc(1);
    tests++; if (cursor !== 2'd0) begin fails++; $display("FAIL entry_cursor: got %0d expected 0", cursor); end
    press(2'b10, 2'b00, 1'b0, 9);
    tests++; if (clock_out !== 16'h0009) begin fails++; $display("FAIL up9: got %h expected 0009", clock_out); end
    press(2'b00, 2'b10, 1'b0, 1);
    press(2'b10, 2'b00, 1'b0, 5);
    tests++; if (clock_out !== 16'h0059 || cursor !== 2'd1) begin fails++; $display("FAIL min1_up5: got %h/%0d expected 0059/1", clock_out, cursor); end
    press(2'b00, 2'b10, 1'b0, 1);
    press(2'b01, 2'b00, 1'b0, 2);
    tests++; if (clock_out !== 16'h0859) begin fails++; $display("FAIL hr0_down2: got %h expected 0859", clock_out); end
    press(2'b00, 2'b10, 1'b0, 1);
    press(2'b01, 2'b00, 1'b0, 1);
    tests++; if (clock_out !== 16'h2359 || cursor !== 2'd3) begin fails++; $display("FAIL load_2359: got %h/%0d expected 2359/3", clock_out, cursor); end
    press(2'b11, 2'b11, 1'b0, 1);
    tests++; if (clock_out !== 16'h2359 || cursor !== 2'd3) begin fails++; $display("FAIL both_11_noop: got %h/%0d expected 2359/3", clock_out, cursor); end
    press(2'b10, 2'b10, 1'b0, 1);
    tests++; if (clock_out !== 16'h0359 || cursor !== 2'd3) begin fails++; $display("FAIL updown_over_lr: got %h/%0d expected 0359/3", clock_out, cursor); end
    press(2'b01, 2'b00, 1'b0, 1);
    tests++; if (clock_out !== 16'h2359) begin fails++; $display("FAIL hr1_down_wrap: got %h expected 2359", clock_out); end
    clock_load = 1'b0;
  endtask

  task automatic test_rollover;
    en = 1'b1; cyc(3);
    tests++; if (clock_out !== 16'h2359) begin fails++; $display("FAIL pre_rollover: got %h expected 2359", clock_out); end
    cyc(1);
    tests++; if (clock_out !== 16'h0000) begin fails++; $display("FAIL rollover: got %h expected 0000", clock_out); end
    en = 1'b0;
  endtask

  task automatic test_min_rst;
    en = 1'b1; cyc(3);
    min_rst = 1'b1; cyc(1); min_rst = 1'b0;
    tests++; if (clock_out !== 16'h0000) begin fails++; $display("FAIL min_rst_beats_tick: got %h expected 0000", clock_out); end
    cyc(3);
    tests++; if (clock_out !== 16'h0000) begin fails++; $display("FAIL min_rst_restart: got %h expected 0000", clock_out); end
    cyc(1);
    tests++; if (clock_out !== 16'h0001) begin fails++; $display("FAIL min_rst_tick: got %h expected 0001", clock_out); end
    en = 1'b0;
  endtask

  task automatic test_clamp;
    clock_load = 1'b1; cyc(1);
    load_value(16'h1800);
    tests++; if (clock_out !== 16'h1800 || cursor !== 2'd0) begin fails++; $display("FAIL set_1800: got %h/%0d expected 1800/0", clock_out, cursor); end
    press(2'b00, 2'b10, 1'b0, 3);
    press(2'b10, 2'b00, 1'b0, 1);
    tests++; if (clock_out !== 16'h2300) begin fails++; $display("FAIL hr_clamp: got %h expected 2300", clock_out); end
    press(2'b10, 2'b00, 1'b0, 1);
    tests++; if (clock_out !== 16'h0300) begin fails++; $display("FAIL hr1_up_wrap: got %h expected 0300", clock_out); end
    press(2'b00, 2'b01, 1'b0, 1);
    tests++; if (cursor !== 2'd2) begin fails++; $display("FAIL right_3_2: got %0d expected 2", cursor); end
    press(2'b00, 2'b01, 1'b0, 3);
    tests++; if (cursor !== 2'd3) begin fails++; $display("FAIL right_wrap: got %0d expected 3", cursor); end
    press(2'b00, 2'b10, 1'b0, 2);
    press(2'b01, 2'b00, 1'b0, 1);
    tests++; if (clock_out !== 16'h0350) begin fails++; $display("FAIL min1_down_wrap: got %h expected 0350", clock_out); end
    press(2'b00, 2'b01, 1'b0, 1);
    press(2'b01, 2'b00, 1'b0, 1);
    tests++; if (clock_out !== 16'h0359) begin fails++; $display("FAIL min0_down_wrap: got %h expected 0359", clock_out); end
    clock_load = 1'b0; cyc(1);
  endtask

  task automatic test_alarm;
    alarm_load = 1'b1; alarm_sel = 1'b1; cyc(1);
    load_value(16'h1524);
    tests++; if (alarm_out !== 16'h1524) begin fails++; $display("FAIL alarm1_load: got %h expected 1524", alarm_out); end
    alarm_sel = 1'b0; #1;
    tests++; if (alarm_out !== 16'h0000) begin fails++; $display("FAIL alarm0_untouched: got %h expected 0000", alarm_out); end
    alarm_sel = 1'b1; alarm_load = 1'b0; cyc(1);
    tests++; if (clock_out !== 16'h0359) begin fails++; $display("FAIL alarm_edit_leaves_time: got %h expected 0359", clock_out); end
    set_time(16'h1523);
    alarm_arm = 2'b10; en = 1'b1; cyc(3);
    tests++; if (ring_id !== 2'b00 || clock_out !== 16'h1523) begin fails++; $display("FAIL pre_match: got %b/%h expected 00/1523", ring_id, clock_out); end
    cyc(1);
    tests++; if (ring_id !== 2'b10 || clock_out !== 16'h1524) begin fails++; $display("FAIL match: got %b/%h expected 10/1524", ring_id, clock_out); end
    en = 1'b0; ack = 1'b1; cyc(1); ack = 1'b0;
    tests++; if (ring_id !== 2'b00) begin fails++; $display("FAIL ack: got %b expected 00", ring_id); end
  endtask

  task automatic test_ring_end;
    set_time(16'h1523);
    en = 1'b1; cyc(4); cyc(3);
    tests++; if (ring_id !== 2'b10) begin fails++; $display("FAIL still_ringing: got %b expected 10", ring_id); end
    cyc(1);
    tests++; if (ring_id !== 2'b00 || clock_out !== 16'h1525) begin fails++; $display("FAIL auto_stop: got %b/%h expected 00/1525", ring_id, clock_out); end
    en = 1'b0;
    set_time(16'h1523);
    en = 1'b1; cyc(3); ack = 1'b1; cyc(1); ack = 1'b0;
    tests++; if (ring_id !== 2'b00 || clock_out !== 16'h1524) begin fails++; $display("FAIL ack_beats_match: got %b/%h expected 00/1524", ring_id, clock_out); end
    en = 1'b0;
    set_time(16'h1523);
    en = 1'b1; cyc(4); en = 1'b0;
    alarm_arm = 2'b00; cyc(1); alarm_arm = 2'b10;
    tests++; if (ring_id !== 2'b00) begin fails++; $display("FAIL disarm: got %b expected 00", ring_id); end
  endtask

  task automatic test_multi;
    alarm_load = 1'b1; alarm_sel = 1'b0; cyc(1);
    load_value(16'h1524);
    alarm_load = 1'b0; alarm_sel = 1'b1;
    set_time(16'h1523);
    alarm_arm = 2'b11; en = 1'b1; cyc(4); en = 1'b0;
    tests++; if (ring_id !== 2'b11) begin fails++; $display("FAIL dual_match: got %b expected 11", ring_id); end
    ack = 1'b1; cyc(1); ack = 1'b0;
    alarm_arm = 2'b10;
  endtask

  task automatic test_snooze;
    set_time(16'h1523);
    en = 1'b1; cyc(4); en = 1'b0;
    tests++; if (ring_id !== 2'b10) begin fails++; $display("FAIL snooze_setup: got %b expected 10", ring_id); end
    snooze = 1'b1; cyc(1); snooze = 1'b0;
`ifdef SNOOZE_EN
    tests++; if (ring_id !== 2'b00) begin fails++; $display("FAIL snooze_clear: got %b expected 00", ring_id); end
    en = 1'b1; cyc(19);
    tests++; if (ring_id !== 2'b00 || clock_out !== 16'h1528) begin fails++; $display("FAIL snooze_wait: got %b/%h expected 00/1528", ring_id, clock_out); end
    cyc(1); en = 1'b0;
    tests++; if (ring_id !== 2'b10 || clock_out !== 16'h1529) begin fails++; $display("FAIL snooze_rering: got %b/%h expected 10/1529", ring_id, clock_out); end
`else
    tests++; if (ring_id !== 2'b10) begin fails++; $display("FAIL snooze_ignored: got %b expected 10", ring_id); end
`endif
  endtask

  task automatic test_reset_mid_load;
    clock_load = 1'b1; cyc(1);
    press(2'b10, 2'b00, 1'b0, 1);
    tests++; if (ring_id !== 2'b10) begin fails++; $display("FAIL ring_before_reset: got %b expected 10", ring_id); end
    #3 rst = 1'b0; #1;
    tests++; if (clock_out !== 16'h0000 || alarm_out !== 16'h0000 || cursor !== 2'd0 || ring_id !== 2'b00)
      begin fails++; $display("FAIL async_reset: got %h/%h/%0d/%b expected 0000/0000/0/00", clock_out, alarm_out, cursor, ring_id); end
    alarm_sel = 1'b0; #1;
    tests++; if (alarm_out !== 16'h0000) begin fails++; $display("FAIL async_reset_alarm0: got %h expected 0000", alarm_out); end
    clock_load = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; min_rst = 1'b0; en = 1'b0; clock_load = 1'b0; alarm_load = 1'b0;
    alarm_sel = 1'b0; load_num_rst = 1'b0; load_up_down = 2'b00; load_left_right = 2'b00;
    alarm_arm = 2'b00; snooze = 1'b0; ack = 1'b0;
    test_reset;
    test_load_2359;
    test_rollover;
    test_min_rst;
    test_clamp;
    test_alarm;
    test_ring_end;
    test_multi;
    test_snooze;
    test_reset_mid_load;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
